spi_slave_port: RTL and testbench

- SPI responder that attaches the design's 8-bit parallel side to an external SPI master's sclk/ss_n/mosi/miso pins.
- It supports all four cpol/cpha modes, selected at runtime.
- All SPI inputs are oversampled and synchronized into the single system clock domain.
- It has a one-entry transmit holding buffer with a valid/ready handshake, and a received-word strobe.

---
 rtl/spi_slave_port.sv | 159 +++++++++++++++
 tb/tb_spi_slave_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_port.sv
// SPI responder: oversampled sclk/ss_n/mosi, all four cpol/cpha modes, one-entry
// transmit holding buffer with valid/ready, and a received-word strobe.
module spi_slave_port #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy
);

  localparam int unsigned   CW       = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]  tx_shift_q, rx_shift_q, buf_q, rx_data_q;
  logic                   buf_full_q, reload_pend_q, rx_done_q, rx_valid_q, underrun_q;

  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic                   ss_fall, ss_rise, active_ok, word_done, word_load, tx_xfer;
  logic [DATA_WIDTH-1:0]  load_word, rx_next;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_q <= {SYNC_STAGES{cpol}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= cpol;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  // word_load covers every word-start: select, cpha=1 completion, cpha=0 deferred reload
  always_comb begin
    sclk_edge   = sclk_s ^ sclk_prev_q;
    lead_edge   = sclk_edge && (sclk_s != cpol);
    trail_edge  = sclk_edge && (sclk_s == cpol);
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
    ss_fall     = ~ss_s & ss_prev_q;
    ss_rise     = ss_s & ~ss_prev_q;
    active_ok   = (state_q == ACTIVE) && !ss_rise;
    word_done   = active_ok && sample_edge && (cnt_q == LAST_BIT);
    word_load   = ((state_q == IDLE) && ss_fall) || (word_done && cpha) ||
                  (active_ok && shift_edge && reload_pend_q);
    load_word   = buf_full_q ? buf_q : IDLE_WORD;
    rx_next     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    tx_xfer     = tx_valid && !buf_full_q;
  end

  // A fill in the same cycle as a load leaves the new word buffered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      buf_full_q <= (buf_full_q && !word_load) || tx_xfer;
      if (tx_xfer) buf_q <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      reload_pend_q <= 1'b0;
      rx_done_q     <= 1'b0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      rx_done_q  <= 1'b0;
      rx_valid_q <= rx_done_q;
      underrun_q <= word_load && !buf_full_q;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q       <= ACTIVE;
            cnt_q         <= '0;
            tx_shift_q    <= load_word;
            rx_shift_q    <= '0;
            reload_pend_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            reload_pend_q <= 1'b0;
          end else if (sample_edge) begin
            rx_shift_q <= rx_next;
            if (cnt_q == LAST_BIT) begin
              cnt_q     <= '0;
              rx_data_q <= rx_next;
              rx_done_q <= 1'b1;
              if (cpha) tx_shift_q <= load_word;
              else      reload_pend_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (shift_edge) begin
            // cpha=1 presents the MSB at load, so the first shift edge of a word holds
            if (reload_pend_q) begin
              tx_shift_q    <= load_word;
              reload_pend_q <= 1'b0;
            end else if (!(cpha && (cnt_q == '0))) begin
              tx_shift_q <= {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miso        = (state_q == ACTIVE) & tx_shift_q[DATA_WIDTH-1];
  assign miso_oe     = (state_q == ACTIVE);
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign busy        = ~ss_s;

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: a bit-banged SPI master against a word-level model of
// the holding buffer (one buffer entry consumed per word-start).
module tb_spi_slave_port;

  localparam int H = 8;  // sclk half-period in clk cycles

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, sclk, ss_n, mosi;
  logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, busy;
  logic [7:0] tx_data, rx_data;

  int         vectors = 0, miscompares = 0;
  int         rx_cnt = 0, ur_cnt = 0;
  logic [7:0] rx_log [256];

  logic       buf_full_m = 1'b0;
  logic [7:0] buf_m = 8'h00;
  int         model_ur = 0;
  logic [7:0] exp_last_rx = 8'h00;

  spi_slave_port #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_WORD(8'h00)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_log[rx_cnt % 256] = rx_data;
        rx_cnt++;
      end
      if (tx_underrun) ur_cnt++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Word-start load as seen by the model: take the buffered word or send idle
  function automatic logic [7:0] model_load();
    if (buf_full_m) begin
      buf_full_m = 1'b0;
      return buf_m;
    end
    model_ur++;
    return 8'h00;
  endfunction

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'b0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    buf_full_m = 1'b1;
    buf_m      = d;
    wait_clk(2);
  endtask

  task automatic run_frame(input logic pol, input logic pha, input int nw,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input int abort_after, input logic refill,
                           input logic [7:0] refill_val);
    logic [7:0] mw, exp_tx, got;
    int rx0, ur0, urm0, bits;
    logic aborted;
    cpol = pol; cpha = pha; sclk = pol; mosi = 1'b0;
    wait_clk(6);
    chk("busy_pre", {31'b0, busy}, 32'd0);
    chk("tx_ready_pre", {31'b0, tx_ready}, {31'b0, !buf_full_m});
    rx0 = rx_cnt; ur0 = ur_cnt; urm0 = model_ur; bits = 0; aborted = 1'b0;
    ss_n = 1'b0;
    wait_clk(6);
    chk("busy_sel", {31'b0, busy}, 32'd1);
    chk("miso_oe_sel", {31'b0, miso_oe}, 32'd1);
    chk("tx_ready_sel", {31'b0, tx_ready}, 32'd1);
    for (int w = 0; w < nw && !aborted; w++) begin
      mw = (w == 0) ? w0 : w1;
      exp_tx = model_load();
      got = 8'h00;
      for (int b = 7; b >= 0 && !aborted; b--) begin
        if (!pha) begin
          mosi = mw[b]; wait_clk(H);
          got = {got[6:0], miso};
          sclk = ~pol; wait_clk(H);
          sclk = pol;
        end else begin
          sclk = ~pol; mosi = mw[b]; wait_clk(H);
          got = {got[6:0], miso};
          sclk = pol; wait_clk(H);
        end
        bits++;
        if (refill && w == 0 && b == 4) push_tx(refill_val);
        if (abort_after != 0 && bits == abort_after) aborted = 1'b1;
      end
      if (!aborted) chk("miso_word", {24'b0, got}, {24'b0, exp_tx});
    end
    if (!aborted) begin
      // the edge after the last bit is itself a word-start while ss_n is still low
      exp_tx = model_load();
      exp_last_rx = (nw == 2) ? w1 : w0;
    end
    wait_clk(H);
    ss_n = 1'b1;
    wait_clk(8);
    chk("rx_count", rx_cnt - rx0, aborted ? 0 : nw);
    if (!aborted) begin
      chk("rx_word0", {24'b0, rx_log[rx0 % 256]}, {24'b0, w0});
      if (nw == 2) chk("rx_word1", {24'b0, rx_log[(rx0 + 1) % 256]}, {24'b0, w1});
    end
    chk("rx_data", {24'b0, rx_data}, {24'b0, exp_last_rx});
    chk("underruns", ur_cnt - ur0, model_ur - urm0);
    chk("busy_post", {31'b0, busy}, 32'd0);
    chk("miso_oe_post", {31'b0, miso_oe}, 32'd0);
    chk("miso_post", {31'b0, miso}, 32'd0);
  endtask

  initial begin
    logic [7:0] r0, r1, rv;
    logic       pre, rf;
    int         md, nw, ab, rx0, ur0;
    reset = 1'b1; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    wait_clk(3);
    chk("rst_miso", {31'b0, miso}, 32'd0);
    chk("rst_miso_oe", {31'b0, miso_oe}, 32'd0);
    chk("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    chk("rst_underrun", {31'b0, tx_underrun}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    wait_clk(3);

    push_tx(8'h69); chk("tx_ready_full", {31'b0, tx_ready}, 32'd0);
    run_frame(1'b0, 1'b0, 1, 8'hA5, 8'h00, 0, 1'b0, 8'h00);
    push_tx(8'hD6); run_frame(1'b0, 1'b1, 1, 8'h3C, 8'h00, 0, 1'b0, 8'h00);
    push_tx(8'h81); run_frame(1'b1, 1'b0, 1, 8'h18, 8'h00, 0, 1'b0, 8'h00);
    push_tx(8'hFD); run_frame(1'b1, 1'b1, 1, 8'h18, 8'h00, 0, 1'b0, 8'h00);
    push_tx(8'h11); run_frame(1'b0, 1'b0, 2, 8'h5A, 8'hC3, 0, 1'b1, 8'hE0);
    push_tx(8'h22); run_frame(1'b0, 1'b1, 2, 8'h96, 8'h0F, 0, 1'b0, 8'h00);
    push_tx(8'h33); run_frame(1'b1, 1'b0, 1, 8'hB7, 8'h00, 5, 1'b0, 8'h00);
    run_frame(1'b1, 1'b0, 1, 8'h4E, 8'h00, 0, 1'b0, 8'h00);

    for (int i = 0; i < 8; i++) begin
      md  = $urandom_range(0, 3);
      pre = 1'($urandom_range(0, 1));
      nw  = $urandom_range(1, 2);
      rf  = (nw == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      r0  = 8'($urandom); r1 = 8'($urandom); rv = 8'($urandom);
      if (pre && !buf_full_m) push_tx(8'($urandom));
      run_frame(md[1], md[0], nw, r0, r1, ab, rf, rv);
    end

    // reset mid-word, then sclk activity with ss_n high
    if (!buf_full_m) push_tx(8'h55);
    cpol = 1'b0; cpha = 1'b0; sclk = 1'b0;
    wait_clk(6);
    rx0 = rx_cnt; ur0 = ur_cnt;
    ss_n = 1'b0;
    wait_clk(6);
    push_tx(8'h77);
    for (int b = 0; b < 3; b++) begin
      mosi = 1'($urandom); wait_clk(H); sclk = 1'b1; wait_clk(H); sclk = 1'b0;
    end
    wait_clk(H / 2);
    reset = 1'b1;
    buf_full_m = 1'b0;
    exp_last_rx = 8'h00;
    wait_clk(2);
    chk("mid_rst_miso_oe", {31'b0, miso_oe}, 32'd0);
    chk("mid_rst_miso", {31'b0, miso}, 32'd0);
    chk("mid_rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    chk("mid_rst_rx_data", {24'b0, rx_data}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    ss_n = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mosi = 1'($urandom); wait_clk(H); sclk = 1'b1; wait_clk(H); sclk = 1'b0;
    end
    wait_clk(8);
    chk("idle_sclk_rx", rx_cnt - rx0, 0);
    chk("idle_sclk_ur", ur_cnt - ur0, 0);
    chk("idle_sclk_oe", {31'b0, miso_oe}, 32'd0);
    chk("idle_sclk_busy", {31'b0, busy}, 32'd0);
    chk("idle_sclk_ready", {31'b0, tx_ready}, 32'd1);
    chk("idle_sclk_rx_data", {24'b0, rx_data}, 32'd0);

    push_tx(8'hC9);
    run_frame(1'b0, 1'b1, 1, 8'h27, 8'h00, 0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
